// File: rtl/tc_ram_dma_pkg.sv
// tc_ram_dma_pkg: shared types and constants for the RAM copy/fill engine.
//   state_t   - engine FSM states
//   MODE_*    - command mode encoding
//   SUM_W     - width of address+length sums (one bit above the 16-bit fields)
package tc_ram_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam int ADDR_W = 16;
  localparam int SUM_W  = ADDR_W + 1;

endpackage

// File: rtl/tc_ram_dma_range_check.sv
// tc_ram_dma_range_check: combinational command validation.
//   i_src, i_dst, i_len : command fields
//   i_mode              : MODE_COPY / MODE_FILL
//   o_range_err         : a touched region runs past MEM_WORDS
//   o_backward          : COPY whose destination overlaps the source tail
import tc_ram_dma_pkg::*;

module tc_ram_dma_range_check #(
  parameter int MEM_WORDS = 256
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_mode,
  output logic              o_range_err,
  output logic              o_backward
);

  localparam logic [SUM_W-1:0] LIMIT = SUM_W'(MEM_WORDS);

  logic [SUM_W-1:0] w_src_end;
  logic [SUM_W-1:0] w_dst_end;
  logic             w_is_copy;

  // One extra bit so src+len cannot wrap and slip past the limit.
  assign w_src_end = {1'b0, i_src} + {1'b0, i_len};
  assign w_dst_end = {1'b0, i_dst} + {1'b0, i_len};
  assign w_is_copy = (i_mode == MODE_COPY);

  assign o_range_err = (w_is_copy && (w_src_end > LIMIT)) || (w_dst_end > LIMIT);

  // Walking backward keeps unread source words from being overwritten first.
  assign o_backward = w_is_copy && (i_dst > i_src) && ({1'b0, i_dst} < w_src_end);

endmodule

// File: rtl/tc_ram_dma.sv
// tc_ram_dma: block copy (memmove) / fill engine, one word per clock, driving
// write port 0 and read port 1 of a RAM.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_start, i_mode         : command strobe (IDLE only), COPY/FILL
//   i_src, i_dst, i_len     : source, destination, word count
//   i_fill_value            : FILL data
//   o_busy, o_done, o_error : status; o_error qualifies the o_done pulse
//   o_ram_*                 : RAM command side; i_ram_out1 is read data
import tc_ram_dma_pkg::*;

module tc_ram_dma #(
  parameter int BIT_WIDTH = 16,
  parameter int MEM_WORDS = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_mode,
  input  logic [ADDR_W-1:0]    i_src,
  input  logic [ADDR_W-1:0]    i_dst,
  input  logic [ADDR_W-1:0]    i_len,
  input  logic [BIT_WIDTH-1:0] i_fill_value,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic                 o_ram_load0,
  output logic                 o_ram_save,
  output logic [ADDR_W-1:0]    o_ram_address0,
  output logic [BIT_WIDTH-1:0] o_ram_in,
  output logic                 o_ram_load1,
  output logic [ADDR_W-1:0]    o_ram_address1,
  input  logic [BIT_WIDTH-1:0] i_ram_out1
);

  state_t               r_state, w_next;
  logic                 r_mode, r_err, r_bwd;
  logic [ADDR_W-1:0]    r_src, r_dst, r_off, r_rem;
  logic [BIT_WIDTH-1:0] r_fill;
  logic                 w_range_err, w_backward;

  tc_ram_dma_range_check #(.MEM_WORDS(MEM_WORDS)) u_range (
    .i_src       (i_src),
    .i_dst       (i_dst),
    .i_len       (i_len),
    .i_mode      (i_mode),
    .o_range_err (w_range_err),
    .o_backward  (w_backward)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_error        = 1'b0;
    o_ram_load0    = 1'b0;
    o_ram_save     = 1'b0;
    o_ram_address0 = '0;
    o_ram_in       = '0;
    o_ram_load1    = 1'b0;
    o_ram_address1 = '0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) w_next = (w_range_err || (i_len == '0)) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        o_busy         = 1'b1;
        o_ram_save     = 1'b1;
        o_ram_address0 = r_dst + r_off;
        if (r_mode == MODE_COPY) begin
          // Read is combinational and the RAM commits the write at negedge,
          // so the word can be forwarded straight through in one cycle.
          o_ram_load1    = 1'b1;
          o_ram_address1 = r_src + r_off;
          o_ram_in       = i_ram_out1;
        end else begin
          o_ram_in = r_fill;
        end
        if (r_rem == ADDR_W'(1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        o_error = r_err;
        w_next  = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= MODE_COPY;
      r_err  <= 1'b0;
      r_bwd  <= 1'b0;
      r_src  <= '0;
      r_dst  <= '0;
      r_off  <= '0;
      r_rem  <= '0;
      r_fill <= '0;
    end else if ((r_state == ST_IDLE) && i_start) begin
      r_mode <= i_mode;
      r_err  <= w_range_err;
      r_bwd  <= w_backward;
      r_src  <= i_src;
      r_dst  <= i_dst;
      r_off  <= w_backward ? (i_len - ADDR_W'(1)) : '0;
      r_rem  <= i_len;
      r_fill <= i_fill_value;
    end else if (r_state == ST_RUN) begin
      r_off <= r_bwd ? (r_off - ADDR_W'(1)) : (r_off + ADDR_W'(1));
      r_rem <= r_rem - ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_tc_ram_dma.sv
// tb_tc_ram_dma: directed and randomized commands against a memmove/fill
// reference model over a 256-word image; RAM is modelled in the bench.
module tb_tc_ram_dma;

  localparam int W = 16;
  localparam int N = 256;

  logic          clk = 1'b0;
  logic          rst, start, mode;
  logic [15:0]   src, dst, len;
  logic [W-1:0]  fill_value;
  logic          busy, done, error, ram_load0, ram_save, ram_load1;
  logic [15:0]   ram_address0, ram_address1;
  logic [W-1:0]  ram_in, ram_out1;

  logic [W-1:0]  mem     [N];
  logic [W-1:0]  ref_mem [N];
  logic          sync_req = 1'b0;
  int            save_cnt = 0;
  int            load_cnt = 0;
  int            addr_q[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tc_ram_dma #(.BIT_WIDTH(W), .MEM_WORDS(N)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_mode         (mode),
    .i_src          (src),
    .i_dst          (dst),
    .i_len          (len),
    .i_fill_value   (fill_value),
    .o_busy         (busy),
    .o_done         (done),
    .o_error        (error),
    .o_ram_load0    (ram_load0),
    .o_ram_save     (ram_save),
    .o_ram_address0 (ram_address0),
    .o_ram_in       (ram_in),
    .o_ram_load1    (ram_load1),
    .o_ram_address1 (ram_address1),
    .i_ram_out1     (ram_out1)
  );

  assign ram_out1 = (ram_address1 < 16'(N)) ? mem[ram_address1[7:0]] : '0;

  // RAM commit at negedge, plus activity counters for the checks.
  always @(negedge clk) begin
    if (sync_req) begin
      for (int i = 0; i < N; i++) mem[i] = ref_mem[i];
    end else begin
      if (ram_save) begin
        save_cnt = save_cnt + 1;
        if (ram_address0 < 16'(N)) mem[ram_address0[7:0]] = ram_in;
      end
      if (ram_load1) begin
        load_cnt = load_cnt + 1;
        addr_q.push_back(int'(ram_address1));
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync_mem();
    sync_req = 1'b1;
    @(negedge clk);
    #1 sync_req = 1'b0;
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, ".mem"}, 32'(bad), 32'd0);
  endtask

  // Issue one command, follow it to completion, then apply the reference model.
  task automatic run_cmd(input bit m, input int s, input int d, input int l,
                         input logic [W-1:0] fv, input int poke, input string tag);
    bit          exp_err, seen, got_err, bwd;
    int          exp_k, k, dk, s0, l0, q0, bad;
    logic [W-1:0] tmp[$];
    exp_err = (d + l > N) || (m == 1'b0 && s + l > N);
    exp_k   = (exp_err || l == 0) ? 0 : l;
    s0 = save_cnt; l0 = load_cnt; q0 = addr_q.size();
    mode = m; src = 16'(s); dst = 16'(d); len = 16'(l); fill_value = fv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; dk = -1; seen = 0; got_err = 0;
    while (k <= l + 3 && !seen) begin
      if (k == 0) chk({tag, ".busy_t0"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1; dk = k; got_err = error;
      end else begin
        if (k == poke) begin
          start = 1'b1; mode = ~m; src = 16'h0; dst = 16'h70; len = 16'd2;
          fill_value = 16'hDEAD;
        end
        @(posedge clk); #1;
        start = 1'b0;
        k++;
      end
    end
    chk({tag, ".done_seen"}, 32'(seen), 32'd1);
    chk({tag, ".done_cycle"}, 32'(dk), 32'(exp_k));
    chk({tag, ".error"}, 32'(got_err), 32'(exp_err));
    @(posedge clk); #1;
    chk({tag, ".idle_after"}, {30'd0, busy, done}, 32'd0);
    // memmove: snapshot the source, then write, so overlap cannot matter
    if (!exp_err) begin
      for (int i = 0; i < l; i++) tmp.push_back(ref_mem[s + i]);
      for (int i = 0; i < l; i++) ref_mem[d + i] = (m == 1'b0) ? tmp[i] : fv;
    end
    cmp_mem(tag);
    chk({tag, ".saves"}, 32'(save_cnt - s0), 32'(exp_err ? 0 : l));
    chk({tag, ".loads"}, 32'(load_cnt - l0), 32'((exp_err || m) ? 0 : l));
    if (!exp_err && m == 1'b0 && l > 0) begin
      bwd = (d > s) && (d < s + l);
      bad = 0;
      for (int i = 0; i < l; i++)
        if (addr_q[q0 + i] != (bwd ? s + l - 1 - i : s + i)) bad++;
      chk({tag, ".rd_order"}, 32'(bad), 32'd0);
    end
  endtask

  initial begin
    int rs, rd, rl;
    bit rm;
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_value = '0;
    for (int i = 0; i < N; i++) ref_mem[i] = W'($urandom);
    sync_mem();
    @(posedge clk); #1;
    chk("reset.status", {29'd0, busy, done, error}, 32'd0);
    chk("reset.ctrl", {29'd0, ram_load0, ram_save, ram_load1}, 32'd0);
    chk("reset.addr", {ram_address0, ram_address1}, 32'd0);
    chk("reset.data", 32'(ram_in), 32'd0);
    // start held together with reset must be ignored
    start = 1'b1; len = 16'd4; dst = 16'h10;
    @(posedge clk); #1;
    chk("rst_start.busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    // forward copy
    ref_mem[16'h10] = 16'hA; ref_mem[16'h11] = 16'hB;
    ref_mem[16'h12] = 16'hC; ref_mem[16'h13] = 16'hD;
    sync_mem();
    run_cmd(1'b0, 16'h10, 16'h40, 4, 16'h0, -1, "copy_fwd");
    chk("copy_fwd.word3", 32'(mem[16'h43]), 32'hD);

    // overlapping copy, must walk backward
    for (int i = 0; i < 4; i++) ref_mem[16'h20 + i] = W'(i + 1);
    sync_mem();
    run_cmd(1'b0, 16'h20, 16'h22, 4, 16'h0, -1, "copy_bwd");
    chk("copy_bwd.word0", 32'(mem[16'h22]), 32'h1);

    // fill at the top of memory
    run_cmd(1'b1, 0, 16'hFC, 4, 16'hBEEF, -1, "fill_top");
    chk("fill_top.last", 32'(mem[16'hFF]), 32'hBEEF);

    // range error and zero length
    run_cmd(1'b0, 16'hFE, 16'h00, 3, 16'h0, -1, "range_err");
    run_cmd(1'b1, 0, 16'hFD, 4, 16'h1234, -1, "fill_err");
    run_cmd(1'b0, 16'h05, 16'h50, 0, 16'h0, -1, "len0");

    // start during RUN with changed fields is ignored
    run_cmd(1'b0, 16'h30, 16'h60, 8, 16'h0, 3, "ign_start");

    // reset two words into a six-word copy
    begin
      int s0;
      bit dseen;
      s0 = save_cnt;
      mode = 1'b0; src = 16'h80; dst = 16'h90; len = 16'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_run.status", {29'd0, busy, done, error}, 32'd0);
      chk("rst_run.ctrl", {29'd0, ram_load0, ram_save, ram_load1}, 32'd0);
      chk("rst_run.addr", {ram_address0, ram_address1}, 32'd0);
      chk("rst_run.data", 32'(ram_in), 32'd0);
      rst = 1'b0;
      dseen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (done || busy) dseen = 1;
      end
      chk("rst_run.no_done", 32'(dseen), 32'd0);
      chk("rst_run.saves", 32'(save_cnt - s0), 32'd2);
      for (int i = 0; i < 2; i++) ref_mem[16'h90 + i] = ref_mem[16'h80 + i];
      cmp_mem("rst_run");
    end

    // randomized commands, biased toward overlap and the top boundary
    for (int t = 0; t < 24; t++) begin
      rm = 1'($urandom_range(0, 1));
      rl = $urandom_range(0, 12);
      rs = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) rd = (rs + $urandom_range(0, 8) - 4 + N) % N;
      else                           rd = $urandom_range(0, N - 1);
      run_cmd(rm, rs, rd, rl, W'($urandom), -1, $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tc_ram_dma.md
# tc_ram_dma

Block-copy / fill engine that drives the command side of a dual-load RAM (write port 0, read port 1). On a start command it copies `len` words from `src` to `dst` (memmove semantics, overlap-safe) or fills `len` words at `dst` with a constant, one word per clock. It sits between a controller and the RAM as the RAM's sole initiator during a transfer.

## Interface
- `BIT_WIDTH`, 16, data word width (matches RAM)
- `MEM_WORDS`, 256, RAM depth; valid addresses 0..MEM_WORDS-1

- `clk`  in  1  clock; all engine state updates on posedge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  command strobe; sampled only in IDLE
- `mode`  in  1  0 = COPY, 1 = FILL
- `src`  in  16  source start address (COPY only)
- `dst`  in  16  destination start address
- `len`  in  16  word count
- `fill_value`  in  BIT_WIDTH  FILL data
- `busy`  out  1  engine in RUN or DONE
- `done`  out  1  one-cycle completion pulse
- `error`  out  1  valid with `done`; range violation, no words written
- `ram_load0`  out  1  tied 0
- `ram_save`  out  1  RAM write enable
- `ram_address0`  out  16  RAM write address
- `ram_in`  out  BIT_WIDTH  RAM write data
- `ram_load1`  out  1  RAM read enable
- `ram_address1`  out  16  RAM read address
- `ram_out1`  in  BIT_WIDTH  RAM read data (combinational from `ram_address1`)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `start`=1 latches `mode`, `src`, `dst`, `len`, `fill_value`.
  - Range check in 17-bit arithmetic: COPY fails if `src+len > MEM_WORDS` or `dst+len > MEM_WORDS`; FILL checks `dst` only.
  - Fail -> DONE with error flag set. `len`=0 and in range -> DONE, no error. Otherwise -> RUN.
- Direction: COPY with `dst > src` and `dst < src+len` runs backward, from offset len-1 down to 0. All other cases run forward, from offset 0 up.
- RUN, per cycle:
  - COPY: `ram_load1`=1, `ram_address1`=src+off, `ram_save`=1, `ram_address0`=dst+off, `ram_in`=`ram_out1` (combinational pass-through).
  - FILL: `ram_load1`=0, `ram_in`=`fill_value`, `ram_save`=1.
  - Remaining counter decrements each cycle; at remaining=1 -> DONE.
- DONE: `done`=1, `error`=latched flag, `busy`=1; next state IDLE.
- `start` outside IDLE is ignored (no queueing).
- Outside RUN: `ram_save`, `ram_load1` are 0, and all RAM address/data outputs are 0.
- Latched command fields do not change during RUN, even if the inputs change.

## Timing
- Reset values: state IDLE; `busy`, `done`, `error`, `ram_save`, `ram_load1`, `ram_load0`=0; `ram_address0`, `ram_address1`, `ram_in`=0.
- `start` accepted at edge T:
  - words are written in cycles T..T+len-1 (RAM commits on the following negedge);
  - `done` is high in cycle T+len;
  - IDLE from T+len+1.
  - A new `start` is accepted at the edge ending cycle T+len+1 at the earliest.
- Error or `len`=0: `done` is high in cycle T; no `ram_save`.
- Throughput: 1 word/cycle. Read and write happen in the same cycle, which is safe because the RAM write lands at negedge after the combinational read; overlap ordering is handled by direction.
- `rst` during RUN: next posedge goes to IDLE with all outputs 0. Words already written stay written. No `done` pulse.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Package `tc_ram_dma_pkg`:
  - state enum (IDLE/RUN/DONE);
  - mode constants `MODE_COPY`=0, `MODE_FILL`=1;
  - 17-bit range-sum width constant.
- Sub-module `tc_ram_dma_range_check`: combinational. Inputs `src`, `dst`, `len`, `mode`. Outputs `range_err` and `backward`.
- Top holds the FSM, the offset counter and the remaining counter.

## Test plan
- COPY forward, src=0x10, dst=0x40, len=4, RAM[0x10..0x13]=A,B,C,D -> RAM[0x40..0x43]=A,B,C,D. `done` pulses exactly 4 cycles after the accepting edge; `error`=0.
- Overlapping COPY backward, src=0x20, dst=0x22, len=4, RAM[0x20..0x23]=1,2,3,4 -> RAM[0x22..0x25]=1,2,3,4. Address sequence 0x23, 0x22, 0x21, 0x20 on `ram_address1`.
- FILL, dst=0xFC, len=4, fill_value=0xBEEF -> RAM[0xFC..0xFF]=0xBEEF. `ram_load1` stays 0 throughout.
- Range error, COPY src=0xFE, len=3 -> `done`=1 and `error`=1 in the accept cycle; zero `ram_save` cycles; RAM unchanged.
- len=0 -> `done` in the accept cycle, `error`=0, no RAM activity. A second `start` pulsed during RUN of a len=8 copy is ignored.
- Assert `rst` after 2 words of a len=6 copy -> only 2 destination words are changed. The next cycle shows all outputs 0 and IDLE, with no `done` pulse.
